idct2_1d_seq: RTL and testbench
===============================

Name: idct2_1d_seq

Overview:
Sequential 1-D inverse DCT-II for VVC, sizes 4/8/16/32. It is the decode-side counterpart of the forward dct2_1d toplevel: it takes a packed coefficient vector and returns a packed residual vector. It computes one output sample per cycle using the VVC 32x32 integer matrix, then applies a rounding shift and a 16-bit clip. It sits after dequantisation in the inverse-transform path and is instantiated once per 1-D pass, with SHIFT set per pass.

Parameters:
SHIFT, 7, right shift applied after accumulation; rounding offset is 1<<(SHIFT-1); SHIFT must be at least 1.
ACC_W, 32, signed accumulator width; must be at least 30.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  reset; synchronous, active-high.
in_valid  in  1  coefficient vector valid.
in_ready  out  1  block can accept a vector.
in_n  in  2  transform size: 00=4, 01=8, 10=16, 11=32.
in_coef  in  [0:511]  32 signed 16-bit coefficients; coef i is bits [16i : 16i+15], MSB first; only i<size is used.
out_valid  out  1  residual vector valid.
out_ready  in  1  downstream accepts the vector.
out_data  out  [0:511]  32 signed 16-bit residuals, same packing; slots k>=size are 0.
out_n  out  2  size of the vector currently on out_data.

Behaviour:
- Reset, synchronous: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_n=0, k=0. Reset wins over any concurrent handshake. Reset during COMPUTE or DONE aborts the operation and discards the vector.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_coef and in_n, clear out_data, set k=0, go to COMPUTE.
  - COMPUTE: in_ready=0, out_valid=0. Each cycle:
    - acc = sum over j<size of T_N[j][k]*c[j], where T_N[j][k] = T32[j*(32/size)][k];
    - y = clip16((acc + (1<<(SHIFT-1))) >>> SHIFT), arithmetic shift;
    - write y to out_data slot k, then k++.
    - When k==size-1, write the last slot and go to DONE.
  - DONE: out_valid=1, out_data and out_n stable. On out_ready go to IDLE. in_ready stays 0 while in DONE.
- Latency: a vector accepted at edge E0 has out_valid high after edge E_size (4/8/16/32 cycles). The earliest next accept is the cycle after the out handshake; there is no overlap. Throughput is one vector per size+2 cycles.
- Masking: coefficients j>=size feed zero into the dot product, whatever the input bits are.
- Arithmetic widths:
  - coef 16b signed × matrix 8b signed gives a 24b product;
  - the 32-term sum fits in 29b; the accumulator is ACC_W;
  - clip16 saturates to [-32768, 32767].
- in_coef and in_n are sampled only at the accept edge. Input changes after that edge have no effect.
- in_valid asserted during COMPUTE or DONE is ignored. The upstream source holds it until in_ready.
- out_ready low holds DONE indefinitely with all outputs frozen.

Decomposition:
- Package idct_pkg:
  - localparam T32, the 32x32 signed 8-bit VVC DCT-II matrix;
  - function size_of(n), returning 4/8/16/32;
  - function clip16;
  - width localparams: COEF_W=16, MAT_W=8;
  - state enum: IDLE, COMPUTE, DONE.
- Sub-module idct2_dot32: combinational 32-multiplier dot product with an adder tree. Inputs are 32 coefficients, the size select and the column index k. It builds the subsampled column T_N[*][k] internally and outputs the ACC_W sum. The top module holds the FSM, the registers, shift/round/clip and the slot write.

Test Plan:
- N=00, c0=64, others 0 → out slots 0-3 = 32 and slots 4-31 = 0. out_valid rises 4 cycles after accept; out_n=00.
- N=11, c0=-128, others 0 → all 32 slots = -64 (-8128>>>7, floor). out_valid 32 cycles after accept.
- N=01, c1=128, others 0, garbage in coefs 8-31 → slots 0-7 = 89, 75, 50, 18, -18, -50, -75, -89; slots 8-31 = 0, confirming input masking.
- N=11, all coefs = 32767 → slot 0 saturates to 32767. All N=11 coefs = -32768 → slot 0 = -32768.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 → out_data stable, in_ready=0, no accept. Release → IDLE, then the next vector is accepted.
- Assert rst for 1 cycle at k=3 of an N=10 run → next cycle state=IDLE, in_ready=1, out_valid=0, out_data=0. A new N=00 vector then completes correctly.

Source files
------------

// File: rtl/idct_pkg.sv
// Shared types, widths and the VVC DCT-II basis for the inverse 1-D transform.
// T32 is the full 32x32 matrix, flattened so entry [j][k] sits at bit (j*32+k)*MAT_W.
package idct_pkg;

    localparam int unsigned COEF_W = 16;
    localparam int unsigned MAT_W  = 8;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;

    // Magnitude of the basis at angle m*pi/64, 0 <= m <= 32.
    function automatic logic [MAT_W-1:0] base_mag(input int m);
        case (m)
            0, 16:   return 8'd64;
            1, 2, 3: return 8'd90;
            4:       return 8'd89;
            5:       return 8'd88;
            6:       return 8'd87;
            7:       return 8'd85;
            8:       return 8'd83;
            9:       return 8'd82;
            10:      return 8'd80;
            11:      return 8'd78;
            12:      return 8'd75;
            13:      return 8'd73;
            14:      return 8'd70;
            15:      return 8'd67;
            17:      return 8'd61;
            18:      return 8'd57;
            19:      return 8'd54;
            20:      return 8'd50;
            21:      return 8'd46;
            22:      return 8'd43;
            23:      return 8'd38;
            24:      return 8'd36;
            25:      return 8'd31;
            26:      return 8'd25;
            27:      return 8'd22;
            28:      return 8'd18;
            29:      return 8'd13;
            30:      return 8'd9;
            31:      return 8'd4;
            default: return 8'd0;
        endcase
    endfunction

    // Folds the angle (2k+1)*j*pi/64 into the first quadrant and applies the cosine sign.
    function automatic logic signed [MAT_W-1:0] t32_entry(input int j, input int k);
        int a;
        a = ((2 * k + 1) * j) % 128;
        if (a <= 32)      return signed'(base_mag(a));
        else if (a <= 64) return -signed'(base_mag(64 - a));
        else if (a <= 96) return -signed'(base_mag(a - 64));
        else              return signed'(base_mag(128 - a));
    endfunction

    function automatic logic [32*32*MAT_W-1:0] gen_t32();
        logic [32*32*MAT_W-1:0] t;
        t = '0;
        for (int j = 0; j < 32; j++) begin
            for (int k = 0; k < 32; k++) begin
                t[(j * 32 + k) * MAT_W +: MAT_W] = t32_entry(j, k);
            end
        end
        return t;
    endfunction

    localparam logic [32*32*MAT_W-1:0] T32 = gen_t32();

    function automatic int unsigned size_of(input logic [1:0] n);
        return 32'd4 << n;
    endfunction

    function automatic logic signed [COEF_W-1:0] clip16(input logic signed [63:0] v);
        if (v > 64'sd32767)  return 16'sh7fff;
        if (v < -64'sd32768) return 16'sh8000;
        return v[15:0];
    endfunction

endpackage

// File: rtl/idct2_dot32.sv
// Combinational dot product of the coefficient vector with column k of the N-point matrix.
module idct2_dot32
    import idct_pkg::*;
#(
    parameter int unsigned ACC_W = 32
) (
    input  logic [0:32*COEF_W-1]    coef_i,
    input  logic [1:0]              n_i,
    input  logic [4:0]              k_i,
    output logic signed [ACC_W-1:0] acc_o
);

    logic signed [MAT_W-1:0]        col  [32];
    logic signed [COEF_W+MAT_W-1:0] prod [32];
    logic signed [ACC_W-1:0]        sum;

    always_comb begin
        sum = '0;
        for (int j = 0; j < 32; j++) begin
            // Row j of the N-point matrix is row j*(32/N) of T32; rows j>=N contribute zero.
            if (j < int'(size_of(n_i))) begin
                col[j] = T32[((j << (3 - int'(n_i))) * 32 + int'(k_i)) * MAT_W +: MAT_W];
            end else begin
                col[j] = '0;
            end
            prod[j] = (COEF_W + MAT_W)'(signed'(coef_i[j * COEF_W +: COEF_W]))
                    * (COEF_W + MAT_W)'(col[j]);
            sum = sum + ACC_W'(prod[j]);
        end
    end

    assign acc_o = sum;

endmodule

// File: rtl/idct2_1d_seq.sv
// Sequential 1-D inverse DCT-II (N = 4/8/16/32), one residual sample per cycle,
// followed by a rounding shift and a 16-bit clip.
module idct2_1d_seq
    import idct_pkg::*;
#(
    parameter int unsigned SHIFT = 7,
    parameter int unsigned ACC_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_n,
    input  logic [0:511] in_coef,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:511] out_data,
    output logic [1:0]   out_n
);

    state_e       state_q, state_d;
    logic [0:511] coef_q, coef_d;
    logic [0:511] data_q, data_d;
    logic [1:0]   n_q, n_d;
    logic [4:0]   k_q, k_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;

    logic signed [ACC_W-1:0]  acc, biased, shifted;
    logic signed [COEF_W-1:0] y;

    idct2_dot32 #(
        .ACC_W (ACC_W)
    ) u_dot (
        .coef_i (coef_q),
        .n_i    (n_q),
        .k_i    (k_q),
        .acc_o  (acc)
    );

    always_comb begin
        biased  = acc + ACC_W'(1 << (SHIFT - 1));
        shifted = biased >>> SHIFT;
        y       = clip16(64'(shifted));
    end

    always_comb begin
        state_d     = state_q;
        coef_d      = coef_q;
        data_d      = data_q;
        n_d         = n_q;
        k_d         = k_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    coef_d     = in_coef;
                    n_d        = in_n;
                    data_d     = '0;
                    k_d        = '0;
                    in_ready_d = 1'b0;
                    state_d    = COMPUTE;
                end
            end
            COMPUTE: begin
                data_d[int'(k_q) * COEF_W +: COEF_W] = y;
                k_d = k_q + 5'd1;
                if (int'(k_q) == int'(size_of(n_q)) - 1) begin
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            coef_q      <= '0;
            data_q      <= '0;
            n_q         <= '0;
            k_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            coef_q      <= coef_d;
            data_q      <= data_d;
            n_q         <= n_d;
            k_q         <= k_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign out_n     = n_q;

endmodule

// File: tb/tb_idct2_1d_seq.sv
// Bench for idct2_1d_seq: directed and random vectors against a cosine-derived reference.
module tb_idct2_1d_seq;

    localparam int SHIFT = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_n;
    logic [0:511] in_coef;
    logic         out_valid;
    logic         out_ready;
    logic [0:511] out_data;
    logic [1:0]   out_n;

    int total = 0;
    int bad   = 0;
    int tmat [32][32];

    logic [0:511] c, cb, got, want;

    idct2_1d_seq #(
        .SHIFT (SHIFT),
        .ACC_W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_n      (in_n),
        .in_coef   (in_coef),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_n     (out_n)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic real rdist(input int m, input real a);
        real d;
        d = real'(m) - a;
        return (d < 0.0) ? -d : d;
    endfunction

    // Ideal basis value 64*sqrt(2)*cos((2k+1)j*pi/64), snapped to the nearest member
    // of the integer coefficient family that the row belongs to.
    function automatic int ref_coef(input int j, input int k);
        real v, a;
        int  fam[$];
        int  best;
        v = 64.0 * $sqrt(2.0) * $cos(3.14159265358979 * (2 * k + 1) * j / 64.0);
        if (j % 16 == 0) return (v < 0.0) ? -64 : 64;
        if (j % 2 == 1)      fam = '{90, 90, 88, 85, 82, 78, 73, 67, 61, 54, 46, 38, 31, 22, 13, 4};
        else if (j % 4 == 2) fam = '{90, 87, 80, 70, 57, 43, 25, 9};
        else if (j % 8 == 4) fam = '{89, 75, 50, 18};
        else                 fam = '{83, 36};
        a = (v < 0.0) ? -v : v;
        best = fam[0];
        foreach (fam[i]) if (rdist(fam[i], a) < rdist(best, a)) best = fam[i];
        return (v < 0.0) ? -best : best;
    endfunction

    function automatic logic [0:511] model(input logic [1:0] n, input logic [0:511] cv);
        logic [0:511] o;
        longint acc, r;
        int sz;
        o  = '0;
        sz = 4 << n;
        for (int k = 0; k < sz; k++) begin
            acc = 0;
            for (int j = 0; j < sz; j++) begin
                acc += longint'(tmat[j * (32 / sz)][k]) * longint'(signed'(cv[16 * j +: 16]));
            end
            r = (acc + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
            if (r > 32767)  r = 32767;
            if (r < -32768) r = -32768;
            o[16 * k +: 16] = 16'(r);
        end
        return o;
    endfunction

    function automatic logic [0:511] rand_vec(input bit mixed);
        logic [0:511] v;
        for (int j = 0; j < 32; j++) begin
            if (!mixed || $urandom_range(0, 3) == 0) v[16 * j +: 16] = 16'($urandom);
            else v[16 * j +: 16] = 16'($urandom_range(0, 1200) - 600);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] n, input logic [0:511] cv);
        in_n     = n;
        in_coef  = cv;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !in_ready; t++) tick();
        check("accept_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        in_n     = 2'($urandom);
        in_coef  = rand_vec(1'b0);
    endtask

    task automatic wait_out(input string tag, input logic [1:0] n, input logic [0:511] expv,
                            output logic [0:511] obs);
        int lat;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, 4 << n);
        check({tag, "_n"}, out_n, n);
        check({tag, "_data"}, out_data, expv);
        obs = out_data;
    endtask

    task automatic run(input string tag, input logic [1:0] n, input logic [0:511] cv,
                       input int hold, output logic [0:511] obs);
        send(n, cv);
        wait_out(tag, n, model(n, cv), obs);
        if (hold > 0) begin
            out_ready = 1'b0;
            for (int i = 0; i < hold; i++) tick();
            check({tag, "_held"}, out_valid, 1'b1);
            out_ready = 1'b1;
        end
        tick();
        check({tag, "_idle"}, in_ready, 1'b1);
    endtask

    initial begin
        for (int j = 0; j < 32; j++) for (int k = 0; k < 32; k++) tmat[j][k] = ref_coef(j, k);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_n      = 2'd0;
        in_coef   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_out_n", out_n, 2'd0);
        rst = 1'b0;
        tick();

        // N=4 DC
        c = '0;
        c[0:15] = 16'sd64;
        want = '0;
        for (int k = 0; k < 4; k++) want[16 * k +: 16] = 16'sd32;
        run("dc4", 2'd0, c, 0, got);
        check("dc4_const", got, want);

        // N=32 negative DC, floor rounding
        c = '0;
        c[0:15] = -16'sd128;
        for (int k = 0; k < 32; k++) want[16 * k +: 16] = -16'sd64;
        run("dc32", 2'd3, c, 0, got);
        check("dc32_const", got, want);

        // N=8 first AC with garbage beyond the active size
        c = rand_vec(1'b0);
        for (int j = 0; j < 8; j++) c[16 * j +: 16] = '0;
        c[16:31] = 16'sd128;
        want = '0;
        want[0:15]    = 16'sd89;
        want[16:31]   = 16'sd75;
        want[32:47]   = 16'sd50;
        want[48:63]   = 16'sd18;
        want[64:79]   = -16'sd18;
        want[80:95]   = -16'sd50;
        want[96:111]  = -16'sd75;
        want[112:127] = -16'sd89;
        run("ac8", 2'd1, c, 0, got);
        check("ac8_const", got, want);

        for (int j = 0; j < 32; j++) c[16 * j +: 16] = 16'sd32767;
        run("satp", 2'd3, c, 0, got);
        check("satp_slot0", got[0:15], 16'h7fff);
        for (int j = 0; j < 32; j++) c[16 * j +: 16] = 16'h8000;
        run("satn", 2'd3, c, 0, got);
        check("satn_slot0", got[0:15], 16'h8000);

        // Backpressure with a pending upstream vector
        out_ready = 1'b0;
        c = rand_vec(1'b1);
        send(2'd1, c);
        wait_out("bp", 2'd1, model(2'd1, c), got);
        cb       = rand_vec(1'b1);
        in_n     = 2'd0;
        in_coef  = cb;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_data", out_data, got);
            check("bp_hold_ready", in_ready, 1'b0);
            check("bp_hold_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", out_valid, 1'b0);
        check("bp_release_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        in_coef  = rand_vec(1'b0);
        wait_out("bp_next", 2'd0, model(2'd0, cb), got);
        tick();

        // Reset at k=3 of an N=16 run
        c = rand_vec(1'b1);
        send(2'd2, c);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_out_data", out_data, '0);
        c = rand_vec(1'b1);
        run("after_abort", 2'd0, c, 0, got);

        for (int i = 0; i < 24; i++) begin
            c = rand_vec(1'b1);
            run($sformatf("rnd%0d", i), 2'($urandom), c, $urandom_range(0, 3), got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
